// File: rtl/seq_divider_pkg.sv
// Shared types and width constants for the sequential restoring divider.
// Optional build macro DIV_ZERO_CHECK_EN is consumed in seq_divider.sv.
package seq_divider_pkg;

   localparam int DIVIDEND_W_DEF = 8;
   localparam int DIVISOR_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold the full iteration count, not just count down to it.
   function automatic int cnt_width(input int dividend_w);
      return $clog2(dividend_w + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract of the divisor
// from the shifted partial remainder, yielding the next remainder and quotient bit.
module div_step
   import seq_divider_pkg::*;
#(
   parameter int DIVISOR_W = DIVISOR_W_DEF
) (
   input  logic [DIVISOR_W:0]   r_shift,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   r_next,
   output logic                 q_bit
);

   logic [DIVISOR_W:0] divisor_ext;

   assign divisor_ext = {1'b0, divisor};

   always_comb begin
      q_bit  = (r_shift >= divisor_ext);
      r_next = q_bit ? (r_shift - divisor_ext) : r_shift;
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Build macro DIV_ZERO_CHECK_EN: short-circuit a zero divisor and flag div_by_zero.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CNT_W = cnt_width(DIVIDEND_W);

   // Handshake: start is accepted on any rising edge where the block is not in RUN
   // (IDLE or the done cycle); done pulses for one cycle when results are valid, and
   // results hold until the next accepted start. start seen during RUN is dropped.

   state_t                state_q, state_d;
   logic [DIVIDEND_W-1:0] q_q, q_d;
   logic [DIVISOR_W:0]    r_q, r_d;
   logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_d, done_d;
   logic [DIVIDEND_W-1:0] quot_d;
   logic [DIVISOR_W-1:0]  rem_d;
   logic                  accept;
   logic [DIVISOR_W:0]    r_shift, r_step;
   logic                  q_bit;
   logic                  unused_r_msb;

   // The top remainder bit only matters transiently inside a step.
   assign unused_r_msb = r_q[DIVISOR_W];
   assign r_shift      = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .r_shift (r_shift),
      .divisor (dvs_q),
      .r_next  (r_step),
      .q_bit   (q_bit)
   );

`ifdef DIV_ZERO_CHECK_EN
   logic dbz_q, dbz_d;
   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      busy_d  = busy;
      done_d  = 1'b0;
      quot_d  = quotient;
      rem_d   = remainder;
`ifdef DIV_ZERO_CHECK_EN
      dbz_d   = dbz_q;
`endif
      accept  = start && (state_q != RUN);

      case (state_q)
         RUN: begin
            q_d   = {q_q[DIVIDEND_W-2:0], q_bit};
            r_d   = r_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               quot_d  = q_d;
               rem_d   = r_step[DIVISOR_W-1:0];
`ifdef DIV_ZERO_CHECK_EN
               dbz_d   = 1'b0;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         q_d     = dividend;
         dvs_d   = divisor;
         r_d     = '0;
         cnt_d   = CNT_W'(DIVIDEND_W);
         state_d = RUN;
         busy_d  = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
         // Zero divisor bypasses iteration with the same values a full run would give.
         if (divisor == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            quot_d  = '1;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         q_q       <= '0;
         r_q       <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
         dbz_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         r_q       <= r_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         busy      <= busy_d;
         done      <= done_d;
         quotient  <= quot_d;
         remainder <= rem_d;
`ifdef DIV_ZERO_CHECK_EN
         dbz_q     <= dbz_d;
`endif
      end
   end

endmodule
